// File: rtl/decoder_scan_nx.sv
// decoder_scan_nx: registered N-to-2^N active-low one-hot decoder with auto-scan, wrap pulse and status index.
// Optional break-before-make blanking on index change: define DEC_BREAK_BEFORE_MAKE_EN.
`default_nettype none

module decoder_scan_nx #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 load,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**SEL_W-1:0]  y_out_n,
    output logic [SEL_W-1:0]     cur_idx,
    output logic                 active,
    output logic                 wrap
);

    localparam int                OUT_N   = 2**SEL_W;
    localparam logic [OUT_N-1:0]  ONE     = {{(OUT_N-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]  IDX_MAX = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_STEP  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [SEL_W-1:0]     idx, idx_nx;
    logic [DWELL_W-1:0]   cnt, cnt_nx;
    logic [OUT_N-1:0]     y_nx;
    logic [SEL_W-1:0]     cur_nx;
    logic                 act_nx;
    logic                 wrap_nx;
    logic                 show;
`ifdef DEC_BREAK_BEFORE_MAKE_EN
    logic                 blank, blank_nx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            y_out_n <= '1;
            cur_idx <= '0;
            active  <= 1'b0;
            wrap    <= 1'b0;
`ifdef DEC_BREAK_BEFORE_MAKE_EN
            blank   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            cnt     <= cnt_nx;
            y_out_n <= y_nx;
            cur_idx <= cur_nx;
            active  <= act_nx;
            wrap    <= wrap_nx;
`ifdef DEC_BREAK_BEFORE_MAKE_EN
            blank   <= blank_nx;
`endif
        end
    end

    // Disabled cycles hold idx/cnt/state so the scan resumes mid-dwell.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        show     = 1'b0;
        y_nx     = '1;
        act_nx   = 1'b0;
        wrap_nx  = 1'b0;
        cur_nx   = cur_idx;
`ifdef DEC_BREAK_BEFORE_MAKE_EN
        blank_nx = blank;
`endif
        if (!en_n) begin
            if (!mode) begin
                state_nx = S_IDLE;
                idx_nx   = sel;
                cnt_nx   = '0;
`ifdef DEC_BREAK_BEFORE_MAKE_EN
                show     = (sel == idx);
                blank_nx = 1'b0;
`else
                show     = 1'b1;
`endif
            end else if (load) begin
                state_nx = S_DWELL;
                idx_nx   = sel;
                cnt_nx   = '0;
`ifdef DEC_BREAK_BEFORE_MAKE_EN
                show     = (sel == idx);
                blank_nx = (sel != idx);
`else
                show     = 1'b1;
`endif
            end else if (state == S_IDLE) begin
                // Entry cycle presents the current index with a fresh count.
                state_nx = S_DWELL;
                cnt_nx   = '0;
                show     = 1'b1;
`ifdef DEC_BREAK_BEFORE_MAKE_EN
                blank_nx = 1'b0;
`endif
            end
`ifdef DEC_BREAK_BEFORE_MAKE_EN
            else if (blank) begin
                state_nx = S_DWELL;
                blank_nx = 1'b0;
                show     = 1'b1;
            end
`endif
            else if (cnt >= dwell) begin
                state_nx = S_STEP;
                idx_nx   = idx + SEL_W'(1);
                cnt_nx   = '0;
                wrap_nx  = (idx == IDX_MAX);
`ifdef DEC_BREAK_BEFORE_MAKE_EN
                blank_nx = 1'b1;
                show     = 1'b0;
`else
                show     = 1'b1;
`endif
            end else begin
                state_nx = S_DWELL;
                cnt_nx   = cnt + DWELL_W'(1);
                show     = 1'b1;
            end
            cur_nx = idx_nx;
            act_nx = show;
            if (show) begin
                y_nx = ~(ONE << idx_nx);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan_nx.sv
// tb_decoder_scan_nx: table vectors, directed corner sequences and randomized checks against a reference model.
`default_nettype none

module tb_decoder_scan_nx;

    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;
    localparam int OUT_N   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en_n;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               load;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_N-1:0]   y_out_n;
    logic [SEL_W-1:0]   cur_idx;
    logic               active;
    logic               wrap;

    decoder_scan_nx #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .en_n(en_n), .mode(mode), .sel(sel), .load(load),
        .dwell(dwell), .y_out_n(y_out_n), .cur_idx(cur_idx), .active(active), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: channel index, position within the dwell, scan-running and blank-pending flags.
    int               m_idx, m_cnt;
    bit               m_scan, m_blank;
    logic [OUT_N-1:0] e_y;
    int               e_cur;
    bit               e_act, e_wrap;

    function automatic logic [OUT_N-1:0] low_at(int i);
        logic [OUT_N-1:0] v;
        v    = '1;
        v[i] = 1'b0;
        return v;
    endfunction

    task automatic model_clock();
        bit show;
        if (en_n) begin
            e_y = '1; e_act = 0; e_wrap = 0;
            return;
        end
        e_wrap = 0;
        show   = 1;
        if (!mode) begin
`ifdef DEC_BREAK_BEFORE_MAKE_EN
            show = (int'(sel) == m_idx);
`endif
            m_idx = int'(sel); m_cnt = 0; m_scan = 0; m_blank = 0;
        end else if (load) begin
`ifdef DEC_BREAK_BEFORE_MAKE_EN
            show    = (int'(sel) == m_idx);
            m_blank = !show;
`endif
            m_idx = int'(sel); m_cnt = 0; m_scan = 1;
        end else if (!m_scan) begin
            m_scan = 1; m_cnt = 0;
        end else if (m_blank) begin
            m_blank = 0;
        end else if (m_cnt >= int'(dwell)) begin
            e_wrap = (m_idx == OUT_N - 1);
            m_idx  = (m_idx + 1) % OUT_N;
            m_cnt  = 0;
`ifdef DEC_BREAK_BEFORE_MAKE_EN
            show    = 0;
            m_blank = 1;
`endif
        end else begin
            m_cnt = m_cnt + 1;
        end
        e_cur = m_idx;
        e_act = show;
        e_y   = show ? low_at(m_idx) : '1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx = 0; m_cnt = 0; m_scan = 0; m_blank = 0;
            e_y = '1; e_cur = 0; e_act = 0; e_wrap = 0;
        end else begin
            model_clock();
        end
    end

    task automatic chk(string name, logic [OUT_N-1:0] ey, int ecur, bit eact, bit ewrap);
        total++;
        if (y_out_n !== ey || cur_idx !== SEL_W'(ecur) || active !== eact || wrap !== ewrap) begin
            bad++;
            $display("FAIL %s: got y=%b cur=%0d act=%b wrap=%b, want y=%b cur=%0d act=%b wrap=%b",
                     name, y_out_n, cur_idx, active, wrap, ey, ecur, eact, ewrap);
        end
    endtask

    task automatic chk_model(string name);
        chk(name, e_y, e_cur, e_act, e_wrap);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             en_n;
        logic [SEL_W-1:0] sel;
        logic [OUT_N-1:0] y;
        int               cur;
        bit               act;
    } dvec_t;

    dvec_t dv[5];

    initial begin
        dv[0] = '{1'b0, 2'd0, 4'b1110, 0, 1'b1};
        dv[1] = '{1'b0, 2'd1, 4'b1101, 1, 1'b1};
        dv[2] = '{1'b0, 2'd2, 4'b1011, 2, 1'b1};
        dv[3] = '{1'b0, 2'd3, 4'b0111, 3, 1'b1};
        dv[4] = '{1'b1, 2'd0, 4'b1111, 3, 1'b0};

        rst = 1'b1; en_n = 1'b1; mode = 1'b0; sel = '0; load = 1'b0; dwell = '0;
        #12;
        chk("reset", 4'b1111, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

`ifndef DEC_BREAK_BEFORE_MAKE_EN
        en_n = 1'b0; mode = 1'b1; dwell = 8'd2;
        for (int k = 0; k < 13; k++) begin
            tick();
            chk("scan_dwell2", low_at((k / 3) % OUT_N), (k / 3) % OUT_N, 1'b1, k == 12);
        end

        tick(); chk_model("scan_cnt1");
        tick(); chk_model("scan_cnt2");
        load = 1'b1; sel = 2'd2;
        tick();
        chk("load_priority", 4'b1011, 2, 1'b1, 1'b0);
        load = 1'b0;

        tick();
        chk("gate_pre", 4'b1011, 2, 1'b1, 1'b0);
        en_n = 1'b1; load = 1'b1; sel = 2'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("gate_off", 4'b1111, 2, 1'b0, 1'b0);
        end
        en_n = 1'b0; load = 1'b0;
        tick(); chk("gate_resume", 4'b1011, 2, 1'b1, 1'b0);
        tick(); chk("gate_step", 4'b0111, 3, 1'b1, 1'b0);
`else
        en_n = 1'b0; mode = 1'b1; dwell = 8'd0;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("bbm_scan", (k % 2 == 0) ? low_at((k / 2) % OUT_N) : 4'b1111,
                ((k + 1) / 2) % OUT_N, k % 2 == 0, k == 7);
        end
        dwell = 8'd2;
        for (int k = 0; k < 6; k++) begin
            tick(); chk_model("bbm_dwell2");
        end
        load = 1'b1; sel = 2'd2;
        tick(); chk_model("bbm_load");
        load = 1'b0;
        tick(); chk_model("bbm_load_show");
`endif

        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en_n = dv[i].en_n;
            sel  = dv[i].sel;
            tick();
`ifndef DEC_BREAK_BEFORE_MAKE_EN
            chk("direct_table", dv[i].y, dv[i].cur, dv[i].act, 1'b0);
`endif
            chk_model("direct_model");
        end

        en_n = 1'b0; mode = 1'b1; dwell = 8'd1;
        for (int k = 0; k < 3; k++) begin
            tick(); chk_model("pre_async");
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset", 4'b1111, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_reset", 4'b1110, 0, 1'b1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            en_n = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            load = ($urandom_range(0, 11) == 0);
            sel  = SEL_W'($urandom_range(0, OUT_N - 1));
            if ($urandom_range(0, 15) == 0) dwell = DWELL_W'($urandom_range(0, 3));
            tick();
            chk_model("random");
            total++;
            if ($countones(~y_out_n) > 1) begin
                bad++;
                $display("FAIL onehot: got y=%b, want at most one low bit", y_out_n);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder_scan_nx.md
Name: decoder_scan_nx

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with active-low outputs and an active-low enable. Generation after the 2x4 combinational decoder.
- Adds a clocked auto-scan mode that steps the active output through all channels with a programmable dwell. Used for display-digit and row strobing.
- Adds a wrap pulse and a status index for downstream sequencing logic.

Parameters:
- SEL_W, 2, select width. Output count OUT_N = 2**SEL_W (localparam). Legal range 1..6.
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en_n  input  1  enable, active-low. 1 forces all outputs inactive.
- mode  input  1  0 = direct decode of sel; 1 = auto-scan.
- sel  input  SEL_W  channel index in direct mode; scan start index on a load.
- load  input  1  one-cycle strobe: scan index <= sel, dwell counter cleared.
- dwell  input  DWELL_W  clocks per channel in scan mode = dwell+1.
- y_out_n  output  OUT_N  registered decode, active-low; exactly one bit low when active.
- cur_idx  output  SEL_W  index currently driven (registered).
- active  output  1  1 when any y_out_n bit is low.
- wrap  output  1  one-cycle pulse when the scan advances from OUT_N-1 to 0.

Behaviour:
- Reset (async, rst=1):
  - y_out_n = all ones, cur_idx = 0, active = 0, wrap = 0.
  - Dwell counter = 0. Internal scan index = 0.
- All outputs are registered on the rising edge of clk. Decode latency is 1 clock from sel/mode/en_n to y_out_n.
- Disabled (en_n=1):
  - Next cycle y_out_n = all ones, active = 0, wrap = 0.
  - Scan index and dwell counter hold.
  - cur_idx holds its last value.
- Direct mode (en_n=0, mode=0):
  - y_out_n <= ~(1 << sel), cur_idx <= sel, active <= 1, wrap <= 0.
  - Dwell counter held at 0. Scan index tracks sel each cycle.
- Scan mode (en_n=0, mode=1), states IDLE / DWELL / STEP:
  - The FSM leaves IDLE on the first enabled scan cycle.
  - In DWELL, the counter increments each clock.
  - When the counter == dwell, go to STEP: index <= index+1 modulo OUT_N, counter <= 0.
  - STEP returns to DWELL in the same cycle (no bubble).
  - y_out_n <= ~(1 << index) with the updated index; cur_idx = index.
  - wrap = 1 for exactly the cycle in which index goes OUT_N-1 -> 0.
  - dwell = 0 advances every clock.
  - If dwell is changed while a dwell is in progress, the new value applies to the comparison immediately. If counter > new dwell, the index steps on the next clock.
- load (en_n=0 only; ignored when en_n=1):
  - Index <= sel, counter <= 0, and sel is reflected on y_out_n next cycle.
  - No wrap is generated by a load, even if sel = 0.
  - load has priority over a STEP in the same cycle.
- Mode switching:
  - Switching 0->1 starts scanning from the current index with counter = 0.
  - Switching 1->0 takes sel on the next edge.
- Reset mid-scan forces the reset values immediately, asynchronous to clk. After release, scanning restarts at index 0.
- SEL_W=1 degenerates to a 1x2 decoder: scan alternates 0,1 and wrap fires every second step.

Optional Feature:
- Macro: DEC_BREAK_BEFORE_MAKE_EN.
- When defined:
  - Every index change (scan step, load, or direct sel change) inserts exactly one blank cycle with y_out_n all ones and active = 0.
  - The new channel goes low the following cycle. Direct-mode latency becomes 2 clocks on a change and 1 clock when sel is unchanged.
  - wrap is asserted in the blank cycle.
  - Dwell counting resumes after the blank cycle, so a scan period per channel = dwell+2.
- When undefined: no blank cycle; timing is as described in Behaviour.

Test Plan:
- Reset/async: assert rst mid-cycle during a scan -> y_out_n=4'b1111, cur_idx=0, active=0, wrap=0 immediately, without waiting for a clock edge.
- Direct decode, SEL_W=2: en_n=0, mode=0, sel=0,1,2,3 on successive clocks -> y_out_n = 1110, 1101, 1011, 0111, each one clock late. en_n=1 -> 1111 next clock.
- Scan with dwell=2: sequence 1110 x3, 1101 x3, 1011 x3, 0111 x3, 1110. wrap is high only on the first 1110 after 0111.
- Load priority: scanning, load=1 with sel=2 on the same cycle a step is due -> next y_out_n=1011, cur_idx=2, wrap=0.
- Enable gating: en_n=1 for 5 clocks mid-dwell -> outputs 1111, load ignored. After en_n=0, the same channel resumes with the preserved dwell count.
- DEC_BREAK_BEFORE_MAKE_EN defined, dwell=0, SEL_W=2: 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111 (wrap=1), 1110. Never two bits low simultaneously.
